// File: rtl/unit_literal_select_if.sv
// Shared literal/clause/formula types and the start/result bundle between
// the driver of a literal selection and unit_literal_select.
package unit_literal_select_pkg;

    localparam int unsigned NUM_CLAUSES     = 10;
    localparam int unsigned LITS_PER_CLAUSE = 5;
    localparam int unsigned IDX_W           = 4;
    localparam int unsigned VAR_W           = 3;

    typedef struct packed {
        logic [VAR_W-1:0] var_id;
        logic             pol;
    } lit_t;

    typedef struct packed {
        logic [IDX_W-1:0]                count;
        lit_t [LITS_PER_CLAUSE-1:0]      lits;
    } clause_t;

    typedef struct packed {
        logic [IDX_W-1:0]                count;
        clause_t [NUM_CLAUSES-1:0]       clauses;
    } formula_t;

    localparam lit_t zero_lit = '0;

endpackage

interface unit_literal_select_if;
    import unit_literal_select_pkg::*;

    logic     start;
    formula_t in_formula;
    logic     busy;
    logic     done;
    logic     find;
    lit_t     sel_lit;
    logic     sel_valid;
    logic     is_unit;
    logic     conflict;
    logic     sat;
    formula_t out_formula;

    modport master (
        output start, in_formula,
        input  busy, done, find, sel_lit, sel_valid, is_unit, conflict, sat, out_formula
    );

    modport slave (
        input  start, in_formula,
        output busy, done, find, sel_lit, sel_valid, is_unit, conflict, sat, out_formula
    );

endinterface

// File: rtl/unit_literal_select.sv
// Scans a latched formula one clause per cycle and picks the next literal to
// propagate: first unit clause, else first multi-literal clause's lits[0].
module unit_literal_select
    import unit_literal_select_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    unit_literal_select_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic             cand_valid, cand_valid_d;
    lit_t             cand_lit, cand_lit_d;
    formula_t         formula_q, formula_d;

    lit_t             sel_lit_q, sel_lit_d;
    logic             sel_valid_q, sel_valid_d;
    logic             is_unit_q, is_unit_d;
    logic             conflict_q, conflict_d;
    logic             sat_q, sat_d;
    logic             done_q, done_d;
    logic             find_q, find_d;
    logic             busy_q, busy_d;

    logic [IDX_W-1:0] clause_idx_c;
    clause_t          cur_clause_c;
    logic             scan_end_c;

    // Saturated idx never addresses past the clause array.
    always_comb begin
        clause_idx_c = (idx < IDX_W'(NUM_CLAUSES)) ? idx : '0;
        cur_clause_c = formula_q.clauses[clause_idx_c];
        scan_end_c   = (idx >= formula_q.count) || (idx >= IDX_W'(NUM_CLAUSES));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            cand_valid  <= 1'b0;
            cand_lit    <= zero_lit;
            formula_q   <= '0;
            sel_lit_q   <= zero_lit;
            sel_valid_q <= 1'b0;
            is_unit_q   <= 1'b0;
            conflict_q  <= 1'b0;
            sat_q       <= 1'b0;
            done_q      <= 1'b0;
            find_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            cand_valid  <= cand_valid_d;
            cand_lit    <= cand_lit_d;
            formula_q   <= formula_d;
            sel_lit_q   <= sel_lit_d;
            sel_valid_q <= sel_valid_d;
            is_unit_q   <= is_unit_d;
            conflict_q  <= conflict_d;
            sat_q       <= sat_d;
            done_q      <= done_d;
            find_q      <= find_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d      = state;
        idx_d        = idx;
        cand_valid_d = cand_valid;
        cand_lit_d   = cand_lit;
        formula_d    = formula_q;
        sel_lit_d    = sel_lit_q;
        sel_valid_d  = sel_valid_q;
        is_unit_d    = is_unit_q;
        conflict_d   = conflict_q;
        sat_d        = sat_q;
        done_d       = 1'b0;
        find_d       = 1'b0;
        busy_d       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    formula_d    = bus.in_formula;
                    idx_d        = '0;
                    cand_valid_d = 1'b0;
                    cand_lit_d   = zero_lit;
                    sel_lit_d    = zero_lit;
                    sel_valid_d  = 1'b0;
                    is_unit_d    = 1'b0;
                    conflict_d   = 1'b0;
                    sat_d        = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = SCAN;
                end
            end

            SCAN: begin
                if (scan_end_c) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (cand_valid) begin
                        sel_lit_d   = cand_lit;
                        sel_valid_d = 1'b1;
                        is_unit_d   = 1'b0;
                        find_d      = 1'b1;
                    end else begin
                        sel_valid_d = 1'b0;
                        sat_d       = (formula_q.count == '0);
                    end
                end else if (cur_clause_c.count == '0) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    conflict_d  = 1'b1;
                    sel_valid_d = 1'b0;
                end else if (cur_clause_c.count == IDX_W'(1)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    find_d      = 1'b1;
                    sel_lit_d   = cur_clause_c.lits[0];
                    sel_valid_d = 1'b1;
                    is_unit_d   = 1'b1;
                end else begin
                    // Oversized clause counts fall here too; lits[0] is still the pick.
                    if (!cand_valid) begin
                        cand_valid_d = 1'b1;
                        cand_lit_d   = cur_clause_c.lits[0];
                    end
                    busy_d = 1'b1;
                    idx_d  = (idx == IDX_W'(NUM_CLAUSES)) ? idx : idx + IDX_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.find        = find_q;
    assign bus.sel_lit     = sel_lit_q;
    assign bus.sel_valid   = sel_valid_q;
    assign bus.is_unit     = is_unit_q;
    assign bus.conflict    = conflict_q;
    assign bus.sat         = sat_q;
    assign bus.out_formula = formula_q;

endmodule

// File: tb/tb_unit_literal_select.sv
// Directed, table-driven bench for unit_literal_select plus reset sequences.
module tb_unit_literal_select;
    import unit_literal_select_pkg::*;

    logic clock;
    logic reset;

    unit_literal_select_if bus_if ();

    unit_literal_select dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        formula_t f;
        int       exp_cyc;
        lit_t     exp_lit;
        logic     exp_valid;
        logic     exp_unit;
        logic     exp_conflict;
        logic     exp_sat;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    int n_total;
    int n_pass;

    function automatic lit_t mk(input int v, input int p);
        lit_t l;
        l.var_id = VAR_W'(v);
        l.pol    = 1'(p);
        return l;
    endfunction

    function automatic clause_t mkc(input int cnt, input lit_t l0, input lit_t l1);
        clause_t c;
        c         = '0;
        c.count   = IDX_W'(cnt);
        c.lits[0] = l0;
        c.lits[1] = l1;
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic check_formula(input string name, input formula_t act, input formula_t exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic run_vec(input int i);
        int   cyc;
        logic got;
        lit_t held;
        bus_if.in_formula = vecs[i].f;
        bus_if.start      = 1'b1;
        @(negedge clock);
        cyc = 1;
        check($sformatf("v%0d_busy_c1", i), 32'(bus_if.busy), 32'd1);
        check($sformatf("v%0d_clear_on_accept", i),
              {27'd0, bus_if.done, bus_if.sel_valid, bus_if.sat, bus_if.conflict, bus_if.find}, 32'd0);
        // Start held high and a garbage input during the scan must both be ignored.
        bus_if.in_formula = ~vecs[i].f;
        got = 1'b0;
        while (cyc < 40) begin
            if (bus_if.done) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
            cyc++;
        end
        bus_if.start = 1'b0;
        check($sformatf("v%0d_done_seen", i), 32'(got), 32'd1);
        if (got) begin
            check($sformatf("v%0d_done_cycle", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            check($sformatf("v%0d_sel_lit", i), 32'(bus_if.sel_lit), 32'(vecs[i].exp_lit));
            check($sformatf("v%0d_sel_valid", i), 32'(bus_if.sel_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_find", i), 32'(bus_if.find), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_is_unit", i), 32'(bus_if.is_unit), 32'(vecs[i].exp_unit));
            check($sformatf("v%0d_conflict", i), 32'(bus_if.conflict), 32'(vecs[i].exp_conflict));
            check($sformatf("v%0d_sat", i), 32'(bus_if.sat), 32'(vecs[i].exp_sat));
            check($sformatf("v%0d_busy_done", i), 32'(bus_if.busy), 32'd0);
            check_formula($sformatf("v%0d_out_formula", i), bus_if.out_formula, vecs[i].f);
        end
        held = bus_if.sel_lit;
        @(negedge clock);
        check($sformatf("v%0d_after_pulse", i),
              {29'd0, bus_if.done, bus_if.find, bus_if.busy}, 32'd0);
        check($sformatf("v%0d_hold_lit", i), 32'(bus_if.sel_lit), 32'(vecs[i].exp_lit));
        check($sformatf("v%0d_hold_lit_stable", i), 32'(bus_if.sel_lit), 32'(held));
    endtask

    initial begin
        formula_t f;
        n_total = 0;
        n_pass  = 0;

        // v0: unit clause at index 4 after multi-literal clauses
        f = '0; f.count = IDX_W'(10);
        f.clauses[0] = mkc(5, mk(5, 0), mk(1, 1));
        f.clauses[1] = mkc(2, mk(6, 1), mk(2, 0));
        f.clauses[2] = mkc(3, mk(7, 0), mk(3, 1));
        f.clauses[3] = mkc(2, mk(2, 1), mk(4, 0));
        f.clauses[4] = mkc(1, mk(1, 1), mk(0, 0));
        for (int k = 5; k < 10; k++) f.clauses[k] = mkc(2, mk(3, 0), mk(4, 1));
        vecs[0] = '{f, 6, mk(1, 1), 1'b1, 1'b1, 1'b0, 1'b0};

        // v1: no unit clause, decision from clause 0
        f = '0; f.count = IDX_W'(4);
        f.clauses[0] = mkc(2, mk(2, 0), mk(5, 0));
        f.clauses[1] = mkc(3, mk(4, 1), mk(1, 1));
        f.clauses[2] = mkc(2, mk(1, 0), mk(3, 0));
        f.clauses[3] = mkc(4, mk(6, 1), mk(7, 1));
        vecs[1] = '{f, 6, mk(2, 0), 1'b1, 1'b0, 1'b0, 1'b0};

        // v2: empty clause at index 1 beats later unit
        f = '0; f.count = IDX_W'(3);
        f.clauses[0] = mkc(2, mk(3, 1), mk(2, 1));
        f.clauses[1] = mkc(0, mk(5, 1), mk(0, 0));
        f.clauses[2] = mkc(1, mk(7, 1), mk(0, 0));
        vecs[2] = '{f, 3, zero_lit, 1'b0, 1'b0, 1'b1, 1'b0};

        // v3: empty formula; clause contents outside range ignored
        f = '0; f.count = '0;
        f.clauses[0] = mkc(1, mk(5, 1), mk(0, 0));
        vecs[3] = '{f, 2, zero_lit, 1'b0, 1'b0, 1'b0, 1'b1};

        // v4: unit at clause 0 right after the sat result
        f = '0; f.count = IDX_W'(2);
        f.clauses[0] = mkc(1, mk(6, 0), mk(0, 0));
        f.clauses[1] = mkc(2, mk(1, 1), mk(2, 1));
        vecs[4] = '{f, 2, mk(6, 0), 1'b1, 1'b1, 1'b0, 1'b0};

        // v5: count above NUM_CLAUSES, idx saturates and scan ends
        f = '0; f.count = IDX_W'(12);
        for (int k = 0; k < 10; k++) f.clauses[k] = mkc(2, mk(k % 8, 0), mk(1, 1));
        f.clauses[0] = mkc(2, mk(7, 1), mk(1, 0));
        vecs[5] = '{f, 12, mk(7, 1), 1'b1, 1'b0, 1'b0, 1'b0};

        // v6: clause count above LITS_PER_CLAUSE treated as multi-literal
        f = '0; f.count = IDX_W'(1);
        f.clauses[0] = mkc(7, mk(4, 1), mk(3, 0));
        vecs[6] = '{f, 3, mk(4, 1), 1'b1, 1'b0, 1'b0, 1'b0};

        // v7: candidate recorded, then empty clause -> conflict wins
        f = '0; f.count = IDX_W'(2);
        f.clauses[0] = mkc(2, mk(4, 1), mk(5, 1));
        f.clauses[1] = mkc(0, mk(0, 0), mk(0, 0));
        vecs[7] = '{f, 3, zero_lit, 1'b0, 1'b0, 1'b1, 1'b0};

        // v8: unit at the last clause slot
        f = '0; f.count = IDX_W'(10);
        for (int k = 0; k < 9; k++) f.clauses[k] = mkc(3, mk(5, 1), mk(6, 0));
        f.clauses[9] = mkc(1, mk(0, 1), mk(0, 0));
        vecs[8] = '{f, 11, mk(0, 1), 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset held two cycles with start high
        reset             = 1'b1;
        bus_if.start      = 1'b1;
        bus_if.in_formula = vecs[0].f;
        @(negedge clock);
        @(negedge clock);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        check("rst_sel_lit", 32'(bus_if.sel_lit), 32'(zero_lit));
        check("rst_flags", {28'd0, bus_if.sel_valid, bus_if.is_unit, bus_if.conflict, bus_if.sat}, 32'd0);
        check_formula("rst_out_formula", bus_if.out_formula, '0);
        reset        = 1'b0;
        bus_if.start = 1'b0;
        @(negedge clock);
        check("rst_no_scan", 32'(bus_if.busy), 32'd0);

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // Reset in cycle 3 of a 10-clause scan aborts it
        bus_if.in_formula = vecs[0].f;
        bus_if.start      = 1'b1;
        @(negedge clock);
        bus_if.start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("abort_busy_pre", 32'(bus_if.busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy", 32'(bus_if.busy), 32'd0);
        check("abort_done", 32'(bus_if.done), 32'd0);
        check("abort_sel_lit", 32'(bus_if.sel_lit), 32'(zero_lit));
        check_formula("abort_out_formula", bus_if.out_formula, '0);
        reset = 1'b0;
        @(negedge clock);
        check("abort_idle", {30'd0, bus_if.done, bus_if.busy}, 32'd0);
        run_vec(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/unit_literal_select.md
Name: unit_literal_select

Overview:
- Upstream stage of propagateliteral. Scans a formula one clause per cycle and chooses the next literal to propagate.
- Selection order, first match wins:
  - a unit clause (forced assignment);
  - otherwise the first multi-literal clause (decision literal).
- Also flags a conflict (empty clause) or satisfaction (empty formula) before propagation is attempted.
- Drives propagateliteral's find, in_lit and in_formula directly.

Parameters:
- NUM_CLAUSES, 10, clause slots in a formula (matches common::formula).
- LITS_PER_CLAUSE, 5, literal slots per clause (matches common::clause).
- IDX_W, 4, width of the clause index and formula count fields.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a selection on in_formula; sampled only in IDLE.
- in_formula  input  formula  formula to scan; latched on accepted start.
- busy  output  1  high while a scan is in progress (SCAN state).
- done  output  1  one-cycle pulse; result outputs are valid from this cycle on.
- find  output  1  one-cycle pulse coincident with done when sel_valid=1; drives propagateliteral.find.
- sel_lit  output  lit  selected literal {var, polarity}; drives propagateliteral.in_lit.
- sel_valid  output  1  a literal was selected.
- is_unit  output  1  sel_lit came from a unit clause (0 = decision literal).
- conflict  output  1  an empty clause was found inside the valid range.
- sat  output  1  formula count is 0.
- out_formula  output  formula  registered copy of the latched formula; drives propagateliteral.in_formula.

Behaviour:
- Reset (synchronous, active-high):
  - State to IDLE; all 1-bit outputs 0.
  - sel_lit = zero_lit; out_formula all zero; idx = 0; candidate register cleared.
  - Reset overrides start in the same cycle.
  - Reset during SCAN aborts the scan: no done pulse, outputs cleared.
- Clause validity: only clauses at index 0 .. formula.count-1 are valid. Valid literals of a clause occupy slots 0 .. clause.count-1.
- IDLE:
  - On start=1: latch in_formula into out_formula, idx <= 0, clear candidate, go to SCAN, busy=1 from the next cycle.
  - Result outputs keep their previous values until this accept edge, where they are cleared.
- SCAN: each cycle examines clause[idx] of out_formula. Priority per cycle:
  1. idx >= formula.count (includes count=0):
     - candidate held: sel_lit = candidate lit, sel_valid=1, is_unit=0.
     - no candidate: count=0 gives sat=1; otherwise sel_valid=0 (all valid clauses degenerate).
     - Go to DONE.
  2. clause.count == 0: conflict=1, sel_valid=0, go to DONE.
  3. clause.count == 1: sel_lit = clause.lits[0], sel_valid=1, is_unit=1, go to DONE.
  4. Else, if no candidate yet: record clause.lits[0] as candidate. Then idx <= idx+1, stay in SCAN.
- Degenerate clause counts: count > LITS_PER_CLAUSE is treated as a multi-literal clause; lits[0] is used.
- DONE (one cycle): done=1, busy=0; find=1 if sel_valid. Next state IDLE. Result outputs hold until the next accepted start.
- Latency: start accepted at edge E0.
  - Decision made at clause k → done high in cycle k+2 after the start cycle.
  - No-unit scan of N valid clauses → done in cycle N+2.
  - Empty formula → done in cycle 2.
- Decision polarity is copied from the clause literal, so the chosen decision satisfies that clause.
- start while busy or in DONE is ignored (no queueing).
- in_formula changes after acceptance have no effect; out_formula stays stable through DONE and until the next accepted start.
- No arithmetic beyond the idx increment. idx saturates at NUM_CLAUSES: a scan with count > NUM_CLAUSES ends as if idx >= count.

Test Plan:
- Reset held 2 cycles with start=1 → busy=0, done=0, sel_lit=zero_lit, no scan starts.
- 10-clause formula, clause 4 = {(1,1)} count 1, clauses 0-3 count 5/2/3/2; pulse start → done and find in cycle 6, sel_lit={3'b001,1'b1}, is_unit=1, out_formula equals the input.
- 4-clause formula, clause 0 = {(2,0),(5,0)}, all clauses count ≥2 → done in cycle 6, sel_lit={3'b010,1'b0}, is_unit=0, sel_valid=1, find=1.
- Formula count 3, clause 1 count 0, clause 2 unit → conflict=1, sel_valid=0, find=0, done in cycle 3.
- Formula count 0 → done in cycle 2, sat=1, sel_valid=0, find=0. Then a second start with a unit formula → results clear on accept and a fresh result appears.
- Reset asserted in cycle 3 of a 10-clause scan → no done pulse, outputs zero next cycle. A start one cycle later completes normally.
